// File: rtl/axis_reg_pkg.sv
// rtl/axis_reg_pkg.sv - shared opcodes, status codes, header layout and states for axis_reg_responder
package axis_reg_pkg;

  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;

  localparam logic [3:0] ST_OK         = 4'h0;
  localparam logic [3:0] ST_BAD_OPCODE = 4'h1;
  localparam logic [3:0] ST_RANGE      = 4'h2;
  localparam logic [3:0] ST_FRAMING    = 4'h3;

  // Header layout: [31:28] opcode, [27:24] status (response), [15:8] length, [7:0] address
  localparam int OP_LSB   = 28;
  localparam int ST_LSB   = 24;
  localparam int LEN_LSB  = 8;
  localparam int ADDR_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_DRAIN,
    S_RESP_HDR,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_SEND
  } state_t;

endpackage

// File: rtl/axis_reg_responder.sv
// rtl/axis_reg_responder.sv - executes stream read/write requests on a register bus
// and returns one response packet per request.
module axis_reg_responder
  import axis_reg_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [31:0]          s_axis_tdata,
  input  logic                 s_axis_tlast,
  input  logic [3:0]           s_axis_tid,
  input  logic [3:0]           s_axis_tdest,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [31:0]          m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic [3:0]           m_axis_tkeep,
  output logic [3:0]           m_axis_tstrb,
  output logic [3:0]           m_axis_tid,
  output logic [3:0]           m_axis_tdest,
  output logic                 reg_wr_en,
  output logic                 reg_rd_en,
  output logic [ADDR_W-1:0]    reg_addr,
  output logic [31:0]          reg_wdata,
  input  logic [31:0]          reg_rdata,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_t      state;
  logic [27:0] hdr;        // request header without its [27:24] field
  logic [3:0]  status;
  logic [7:0]  k;
  logic        ready_q;
  logic        rd_ok;

  logic [7:0]  len, base;
  logic        hs_in, hs_out, last_k;
  logic [3:0]  in_op, chk;
  logic [27:0] in_hdr, fin_src;
  logic        fin, fin_rd;
  logic [3:0]  fin_st;

  function automatic logic [3:0] check_hdr(input logic [3:0] op, input logic [7:0] n,
                                           input logic [7:0] a);
    logic [8:0] last_addr;
    last_addr = {1'b0, a} + {1'b0, n} - 9'd1;
    if (op != OP_READ && op != OP_WRITE) return ST_BAD_OPCODE;
    if (n == 8'd0) return ST_RANGE;
    if (last_addr > 9'((1 << ADDR_W) - 1)) return ST_RANGE;
    if ((a >> ADDR_W) != 8'd0) return ST_RANGE;
    return ST_OK;
  endfunction

  assign in_op   = s_axis_tdata[OP_LSB +: 4];
  assign in_hdr  = {s_axis_tdata[31:28], s_axis_tdata[23:0]};
  assign chk     = check_hdr(in_op, s_axis_tdata[LEN_LSB +: 8], s_axis_tdata[ADDR_LSB +: 8]);
  assign len     = hdr[LEN_LSB +: 8];
  assign base    = hdr[ADDR_LSB +: 8];
  assign last_k  = (k == len - 8'd1);
  assign hs_in   = s_axis_tvalid & ready_q;
  assign hs_out  = m_axis_tvalid & m_axis_tready;
  assign fin_src = (state == S_IDLE) ? in_hdr : hdr;

  assign s_axis_tready = ready_q;
  assign m_axis_tkeep  = 4'hF;
  assign m_axis_tstrb  = 4'hF;
  assign busy          = (state != S_IDLE);
  assign reg_wr_en     = (state == S_WR_DATA) & hs_in;
  assign reg_rd_en     = (state == S_RD_REQ);
  assign reg_addr      = base[ADDR_W-1:0] + k[ADDR_W-1:0];
  assign reg_wdata     = reg_wr_en ? s_axis_tdata : 32'd0;

  // Request packet ends this cycle: the response header goes out next cycle.
  always_comb begin
    fin    = 1'b0;
    fin_st = ST_OK;
    fin_rd = 1'b0;
    if (hs_in && s_axis_tlast) begin
      case (state)
        S_IDLE: begin
          fin    = 1'b1;
          fin_st = (chk != ST_OK) ? chk : (in_op == OP_WRITE) ? ST_FRAMING : ST_OK;
          fin_rd = (chk == ST_OK) && (in_op == OP_READ);
        end
        S_WR_DATA: begin
          fin    = 1'b1;
          fin_st = last_k ? ST_OK : ST_FRAMING;
        end
        S_DRAIN: begin
          fin    = 1'b1;
          fin_st = status;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      hdr           <= '0;
      status        <= ST_OK;
      k             <= '0;
      ready_q       <= 1'b0;
      rd_ok         <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      m_axis_tdest  <= '0;
      err_count     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (hs_in) begin
            hdr          <= in_hdr;
            m_axis_tid   <= s_axis_tid;
            m_axis_tdest <= s_axis_tdest;
            k            <= '0;
            if (!s_axis_tlast) begin
              if (chk != ST_OK) begin
                status <= chk;
                state  <= S_DRAIN;
              end else if (in_op == OP_WRITE) begin
                state <= S_WR_DATA;
              end else begin
                status <= ST_FRAMING;
                state  <= S_DRAIN;
              end
            end
          end
        end
        S_WR_DATA: begin
          if (hs_in && !s_axis_tlast) begin
            if (last_k) begin
              status <= ST_FRAMING;
              state  <= S_DRAIN;
            end else begin
              k <= k + 8'd1;
            end
          end
        end
        S_DRAIN: ;
        S_RESP_HDR: begin
          if (hs_out) begin
            m_axis_tvalid <= 1'b0;
            if (rd_ok) begin
              state <= S_RD_REQ;
            end else begin
              state   <= S_IDLE;
              ready_q <= 1'b1;
              if (status != ST_OK && !(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
            end
          end
        end
        S_RD_REQ: state <= S_RD_WAIT;
        S_RD_WAIT: begin
          m_axis_tdata  <= reg_rdata;
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= last_k;
          state         <= S_RD_SEND;
        end
        S_RD_SEND: begin
          if (hs_out) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            if (last_k) begin
              state   <= S_IDLE;
              ready_q <= 1'b1;
            end else begin
              k     <= k + 8'd1;
              state <= S_RD_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (fin) begin
        state         <= S_RESP_HDR;
        ready_q       <= 1'b0;
        status        <= fin_st;
        rd_ok         <= fin_rd;
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= {fin_src[27:24], fin_st, fin_src[23:0]};
        m_axis_tlast  <= !fin_rd;
      end
    end
  end

endmodule

// File: doc/axis_reg_responder.md
Name: axis_reg_responder

Overview:
- AXI4-Stream command responder that replaces the loopback FIFO on the IPbus stream path, on the 125 MHz IPbus clock.
- Consumes request packets from the IPbus stream output and executes register reads and writes on a simple single-port register bus.
- Returns one response packet per request on the IPbus stream input.

Parameters:
- ADDR_W, 8, register bus address width; legal range 1..8, so the address space is 2^ADDR_W words.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  IPbus clock (clk125).
- rst  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  request stream valid.
- s_axis_tready  out  1  request stream ready.
- s_axis_tdata  in  32  request word.
- s_axis_tlast  in  1  last word of the request packet.
- s_axis_tid  in  4  request ID.
- s_axis_tdest  in  4  request destination.
- m_axis_tvalid  out  1  response stream valid.
- m_axis_tready  in  1  response stream ready.
- m_axis_tdata  out  32  response word.
- m_axis_tlast  out  1  last word of the response packet.
- m_axis_tkeep  out  4  constant 4'hF.
- m_axis_tstrb  out  4  constant 4'hF.
- m_axis_tid  out  4  latched request tid.
- m_axis_tdest  out  4  latched request tdest.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_addr  out  ADDR_W  register address.
- reg_wdata  out  32  write data.
- reg_rdata  in  32  read data; valid exactly 1 cycle after reg_rd_en.
- busy  out  1  high whenever state != IDLE.
- err_count  out  ERR_CNT_W  count of error responses, saturating.

Behaviour:
- Request header word fields:
  - [31:28] opcode: 1 = READ, 2 = WRITE.
  - [27:16] reserved.
  - [15:8] length N.
  - [7:0] start address A.
- Request packet shapes:
  - WRITE: header followed by N data words; tlast on the Nth data word.
  - READ: header only, with tlast on the header.
- Response packet shape:
  - Header word = request header with [27:24] replaced by a status code.
  - Status codes: 0 OK, 1 BAD_OPCODE, 2 RANGE, 3 FRAMING.
  - Successful READ: header followed by N read words; tlast on the last word.
  - All other responses: header only, with tlast.
- Error checks, evaluated on header acceptance in this priority order:
  - Opcode not 1 or 2 -> BAD_OPCODE.
  - N == 0 -> RANGE.
  - A+N-1 > 2^ADDR_W-1 (computed 9-bit, no wrap) -> RANGE.
  - Address bits [7:ADDR_W] nonzero -> RANGE.
  - Any error means no register access occurs.
- Reset values: all outputs 0, except m_axis_tkeep and m_axis_tstrb = 4'hF; state = IDLE; err_count = 0.
- State machine:
  - IDLE:
    - s_axis_tready = 1.
    - On header handshake: latch header, tid, tdest.
    - Error and tlast=0 -> DRAIN. Error and tlast=1 -> RESP_HDR.
    - WRITE with tlast=1 -> status FRAMING, go to RESP_HDR.
    - WRITE otherwise -> WR_DATA.
    - READ with tlast=0 -> status FRAMING, go to DRAIN.
    - READ otherwise -> RESP_HDR.
  - WR_DATA:
    - s_axis_tready = 1.
    - Each accepted word drives a reg_wr_en pulse in the same cycle: reg_addr = A+k, reg_wdata = tdata.
    - When k == N-1: tlast=1 -> RESP_HDR, status OK; tlast=0 -> status FRAMING, go to DRAIN.
    - tlast=1 with k < N-1: the word is written, status FRAMING, go to RESP_HDR. Earlier writes are not undone.
  - DRAIN:
    - s_axis_tready = 1; accepted words are discarded.
    - The word accepted with tlast=1 -> RESP_HDR.
  - RESP_HDR:
    - s_axis_tready = 0.
    - m_axis_tvalid = 1, tdata = response header.
    - tlast = 1 unless this is a successful READ.
    - On handshake: successful READ -> RD_REQ; otherwise -> IDLE, and err_count++ if status != 0 (saturates).
  - RD_REQ:
    - reg_rd_en pulse for one cycle, reg_addr = A+k.
    - Next state RD_WAIT.
  - RD_WAIT:
    - Capture reg_rdata into the output register.
    - Next state RD_SEND.
  - RD_SEND:
    - m_axis_tvalid = 1 with the captured word; tlast when k == N-1.
    - On handshake: k == N-1 -> IDLE, else k++ and go to RD_REQ.
    - Read throughput is 1 word per 3 cycles; accepted by design.
- m_axis_* outputs are registered and held stable while tvalid=1 and tready=0. tvalid never drops without a handshake.
- At most one request is in flight; no new header is accepted until the response tlast handshake.
- Latency from header handshake (tlast=1) to response header tvalid is 1 cycle.
- rst asserted in any state, mid-packet included: next cycle is IDLE with all outputs at reset values and the response abandoned. The upstream remainder of a packet interrupted by reset is treated as new headers.

Decomposition:
- Shared package axis_reg_pkg holds:
  - Opcode constants OP_READ = 4'h1, OP_WRITE = 4'h2.
  - Status constants ST_OK/ST_BAD_OPCODE/ST_RANGE/ST_FRAMING.
  - Header field bit positions.
  - The state enumeration.
- No sub-module. The header decode/range check stays an internal combinational function.

Test Plan:
- WRITE A=0x10 N=3 data {0xA,0xB,0xC}, tlast on 3rd -> reg_wr_en pulses at 0x10/0x11/0x12 with those data; single response 0x2000_0310 with tlast; err_count=0.
- READ A=0x10 N=3 with reg_rdata model returning 0x100+addr, m_axis_tready toggling 1/0 every cycle -> response words 0x1000_0310, 0x110, 0x111, 0x112 in order, held stable under backpressure; tlast only on 0x112.
- READ A=0xFE N=3 (ADDR_W=8) -> no reg_rd_en; response 0x1200_03FE, tlast; err_count=1.
- Opcode 0x7 header plus 2 extra words, tlast on 3rd -> all 3 words accepted and discarded; response 0x7100_xxxx header only; err_count increments.
- WRITE N=4 with tlast on 2nd data word -> 2 writes issued; response status 3 immediately after the 2nd word; next request is processed normally.
- rst pulsed in RD_SEND mid-burst -> next cycle m_axis_tvalid=0, busy=0, err_count=0; a following READ completes correctly.
